// File: rtl/sum_feeder.sv
// Buffers nonzero host words, then streams them to an external accumulator
// behind a one-cycle active-low go, and checks the returned sum against a running total.
module sum_feeder #(
  parameter int DEPTH = 8,
  parameter int TMO   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        wr_full,
  input  logic        start,
  output logic        busy,
  output logic        go_l,
  output logic [15:0] inA,
  input  logic        done_in,
  input  logic [15:0] sum_in,
  output logic        result_valid,
  output logic [15:0] sum_out,
  output logic [15:0] expected,
  output logic        match,
  output logic        timeout
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, GO, STREAM, TERM} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count, rd_ptr, ptr_next;
  logic [3:0]      wait_cnt;
  logic [15:0]     mem [DEPTH];
  logic            go_l_next;
  logic [15:0]     ina_next;
  logic            leave_term, timed_out;

  assign wr_full = (count == CW'(DEPTH));
  assign busy    = (state != IDLE);

  // go_l and inA are computed for the state being entered so they leave a flop.
  always_comb begin
    state_next = state;
    ptr_next   = rd_ptr;
    go_l_next  = 1'b1;
    ina_next   = '0;
    leave_term = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = GO;
          go_l_next  = 1'b0;
          ina_next   = (count == '0) ? 16'h0000 : mem[AW'(0)];
        end
      end
      GO: begin
        if (count <= CW'(1)) begin
          state_next = TERM;
        end else begin
          state_next = STREAM;
          ptr_next   = CW'(1);
          ina_next   = mem[AW'(1)];
        end
      end
      STREAM: begin
        if (rd_ptr == count - 1'b1) begin
          state_next = TERM;
        end else begin
          ptr_next = rd_ptr + 1'b1;
          ina_next = mem[AW'(rd_ptr + 1'b1)];
        end
      end
      TERM: begin
        if (done_in) begin
          state_next = IDLE;
          leave_term = 1'b1;
          ptr_next   = '0;
        end else if (wait_cnt == 4'(TMO - 1)) begin
          state_next = IDLE;
          leave_term = 1'b1;
          timed_out  = 1'b1;
          ptr_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      go_l   <= 1'b1;
      inA    <= '0;
    end else begin
      state  <= state_next;
      rd_ptr <= ptr_next;
      go_l   <= go_l_next;
      inA    <= ina_next;
    end
  end

  // Zero is the stream terminator, so it is never stored; start beats a same-cycle write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      expected     <= '0;
      wait_cnt     <= '0;
      sum_out      <= '0;
      match        <= 1'b0;
      timeout      <= 1'b0;
      result_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      result_valid <= leave_term;
      wait_cnt     <= (state == TERM) ? wait_cnt + 4'd1 : 4'd0;
      if (state == IDLE && start) begin
        sum_out <= '0;
        match   <= 1'b0;
        timeout <= 1'b0;
      end else if (state == IDLE && wr_en && wr_data != '0 && count < CW'(DEPTH)) begin
        mem[AW'(count)] <= wr_data;
        count           <= count + 1'b1;
        expected        <= expected + wr_data;
      end
      if (leave_term) begin
        count    <= '0;
        expected <= '0;
        if (timed_out) begin
          timeout <= 1'b1;
          match   <= 1'b0;
        end else begin
          sum_out <= sum_in;
          match   <= (sum_in == expected);
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_feeder.sv
// Directed self-checking bench for sum_feeder with a hand-driven accumulator.
module tb_sum_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, start, done_in;
  logic [15:0] wr_data, sum_in;
  logic        wr_full, busy, go_l, result_valid, match, timeout;
  logic [15:0] inA, sum_out, expected;
  int tests = 0;
  int failed = 0;

  sum_feeder #(.DEPTH(8), .TMO(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .start(start), .busy(busy), .go_l(go_l), .inA(inA), .done_in(done_in),
    .sum_in(sum_in), .result_valid(result_valid), .sum_out(sum_out),
    .expected(expected), .match(match), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    wr_data = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Holds done_in with the given sum from start until result_valid; returns cycles from GO.
  task automatic run_with_done(input logic [15:0] s, output int cycles);
    pulse_start();
    done_in = 1'b1;
    sum_in = s;
    cycles = 0;
    while (result_valid !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    done_in = 1'b0;
    sum_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests++; if (go_l !== 1'b1) begin failed++; $display("[TB] FAIL reset_go_l got %b want 1", go_l); end
    tests++; if (inA !== 16'h0) begin failed++; $display("[TB] FAIL reset_inA got %h want 0000", inA); end
    tests++; if ({busy, result_valid, match, timeout, wr_full} !== 5'b0) begin failed++; $display("[TB] FAIL reset_flags got %b want 00000", {busy, result_valid, match, timeout, wr_full}); end
    tests++; if ({sum_out, expected} !== 32'h0) begin failed++; $display("[TB] FAIL reset_sums got %h want 00000000", {sum_out, expected}); end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    write_word(16'd3); write_word(16'd5); write_word(16'd7);
    tests++; if (expected !== 16'd15) begin failed++; $display("[TB] FAIL basic_expected got %0d want 15", expected); end
    pulse_start();
    tests++; if (go_l !== 1'b0 || inA !== 16'd3 || busy !== 1'b1) begin failed++; $display("[TB] FAIL basic_go got go_l=%b inA=%0d busy=%b want 0/3/1", go_l, inA, busy); end
    tick();
    tests++; if (go_l !== 1'b1 || inA !== 16'd5) begin failed++; $display("[TB] FAIL basic_word2 got go_l=%b inA=%0d want 1/5", go_l, inA); end
    tick();
    tests++; if (inA !== 16'd7) begin failed++; $display("[TB] FAIL basic_word3 got %0d want 7", inA); end
    tick();
    tests++; if (inA !== 16'd0 || go_l !== 1'b1 || busy !== 1'b1) begin failed++; $display("[TB] FAIL basic_term got inA=%0d go_l=%b busy=%b want 0/1/1", inA, go_l, busy); end
    done_in = 1'b1; sum_in = 16'd15;
    tick();
    done_in = 1'b0; sum_in = '0;
    tests++; if (result_valid !== 1'b1 || sum_out !== 16'd15 || match !== 1'b1 || timeout !== 1'b0) begin failed++; $display("[TB] FAIL basic_result got rv=%b sum=%0d match=%b tmo=%b want 1/15/1/0", result_valid, sum_out, match, timeout); end
    tests++; if (busy !== 1'b0 || expected !== 16'd0) begin failed++; $display("[TB] FAIL basic_cleared got busy=%b expected=%0d want 0/0", busy, expected); end
    tick();
    tests++; if (result_valid !== 1'b0 || sum_out !== 16'd15) begin failed++; $display("[TB] FAIL basic_pulse got rv=%b sum=%0d want 0/15", result_valid, sum_out); end
  endtask

  task automatic test_mismatch();
    int cyc;
    write_word(16'd3); write_word(16'd5); write_word(16'd7);
    run_with_done(16'd14, cyc);
    tests++; if (cyc !== 4) begin failed++; $display("[TB] FAIL mismatch_latency got %0d want 4", cyc); end
    tests++; if (match !== 1'b0 || sum_out !== 16'd14 || timeout !== 1'b0) begin failed++; $display("[TB] FAIL mismatch_result got match=%b sum=%0d tmo=%b want 0/14/0", match, sum_out, timeout); end
  endtask

  task automatic test_filter_full();
    int cyc;
    write_word(16'd0);
    tests++; if (expected !== 16'd0 || wr_full !== 1'b0) begin failed++; $display("[TB] FAIL filter_zero got expected=%0d full=%b want 0/0", expected, wr_full); end
    for (int i = 0; i < 8; i++) write_word(16'd1);
    tests++; if (wr_full !== 1'b1 || expected !== 16'd8) begin failed++; $display("[TB] FAIL full_set got full=%b expected=%0d want 1/8", wr_full, expected); end
    write_word(16'd1);
    tests++; if (expected !== 16'd8) begin failed++; $display("[TB] FAIL full_drop got %0d want 8", expected); end
    run_with_done(16'd8, cyc);
    tests++; if (cyc !== 9 || match !== 1'b1) begin failed++; $display("[TB] FAIL full_run got cycles=%0d match=%b want 9/1", cyc, match); end
    tests++; if (wr_full !== 1'b0) begin failed++; $display("[TB] FAIL full_clear got %b want 0", wr_full); end
  endtask

  task automatic test_wrap();
    int cyc;
    write_word(16'hFFFF); write_word(16'h0002);
    tests++; if (expected !== 16'h0001) begin failed++; $display("[TB] FAIL wrap_expected got %h want 0001", expected); end
    wr_en = 1'b1; wr_data = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0; wr_data = '0;
    tests++; if (expected !== 16'h0001 || go_l !== 1'b0 || inA !== 16'hFFFF) begin failed++; $display("[TB] FAIL start_beats_write got expected=%h go_l=%b inA=%h want 0001/0/ffff", expected, go_l, inA); end
    done_in = 1'b1; sum_in = 16'h0001;
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    done_in = 1'b0; sum_in = '0;
    tests++; if (cyc !== 3 || match !== 1'b1 || sum_out !== 16'h0001) begin failed++; $display("[TB] FAIL wrap_result got cycles=%0d match=%b sum=%h want 3/1/0001", cyc, match, sum_out); end
  endtask

  task automatic test_timeout();
    int cyc;
    pulse_start();
    tests++; if (go_l !== 1'b0 || inA !== 16'd0) begin failed++; $display("[TB] FAIL empty_go got go_l=%b inA=%h want 0/0000", go_l, inA); end
    tests++; if (sum_out !== 16'd0 || match !== 1'b0) begin failed++; $display("[TB] FAIL start_clears got sum=%h match=%b want 0000/0", sum_out, match); end
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 60) begin tick(); cyc++; end
    tests++; if (cyc !== 17) begin failed++; $display("[TB] FAIL timeout_latency got %0d want 17", cyc); end
    tests++; if (timeout !== 1'b1 || match !== 1'b0 || sum_out !== 16'd0 || busy !== 1'b0) begin failed++; $display("[TB] FAIL timeout_flags got tmo=%b match=%b sum=%h busy=%b want 1/0/0000/0", timeout, match, sum_out, busy); end
    tick();
    tests++; if (result_valid !== 1'b0 || timeout !== 1'b1) begin failed++; $display("[TB] FAIL timeout_hold got rv=%b tmo=%b want 0/1", result_valid, timeout); end
    done_in = 1'b1; sum_in = 16'd55;
    tick(); tick();
    done_in = 1'b0; sum_in = '0;
    tests++; if (sum_out !== 16'd0 || result_valid !== 1'b0 || busy !== 1'b0) begin failed++; $display("[TB] FAIL done_idle_ignored got sum=%h rv=%b busy=%b want 0000/0/0", sum_out, result_valid, busy); end
  endtask

  task automatic test_reset_midrun();
    int pulses;
    write_word(16'd3); write_word(16'd5); write_word(16'd7);
    pulse_start();
    tick();
    tests++; if (inA !== 16'd5) begin failed++; $display("[TB] FAIL midrun_word2 got %0d want 5", inA); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (go_l !== 1'b1 || inA !== 16'd0 || busy !== 1'b0 || expected !== 16'd0 || wr_full !== 1'b0) begin failed++; $display("[TB] FAIL midrun_abort got go_l=%b inA=%h busy=%b expected=%h want 1/0000/0/0000", go_l, inA, busy, expected); end
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (result_valid === 1'b1) pulses++; end
    tests++; if (pulses !== 0 || busy !== 1'b0) begin failed++; $display("[TB] FAIL midrun_no_result got pulses=%0d busy=%b want 0/0", pulses, busy); end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0; done_in = 1'b0; sum_in = '0;
    test_reset();
    test_basic();
    test_mismatch();
    test_filter_full();
    test_wrap();
    test_timeout();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
